// File: rtl/speck_seq_pkg.sv
// Shared definitions for the Speck core sequencer: FSM encoding, default widths and small helpers.
package speck_seq_pkg;

  localparam int unsigned BlockWDef  = 64;
  localparam int unsigned KeyWDef    = 128;
  localparam int unsigned TimeoutDef = 255;
  localparam int unsigned CntW       = 8;

  typedef enum logic [2:0] {
    StIdle,
    StKeyLoad,
    StKeyWait,
    StStart,
    StWait,
    StResp
  } seq_state_e;

  function automatic logic [1:0] onehot2(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/speck_core_sequencer_arb.sv
// Two-way round-robin arbiter; the last-served port is recorded only when update_i is pulsed.
module speck_rr_arb2
  import speck_seq_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  input  logic       upd_i,
  input  logic       upd_idx_i,
  output logic [1:0] gnt_o,
  output logic       gnt_idx_o
);

  logic last_q;

  // Reset to port 1 so that port 0 wins the first tie.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_q <= 1'b1;
    end else if (upd_i) begin
      last_q <= upd_idx_i;
    end
  end

  always_comb begin
    gnt_idx_o = 1'b0;
    unique case (req_i)
      2'b11:   gnt_idx_o = ~last_q;
      2'b10:   gnt_idx_o = 1'b1;
      default: gnt_idx_o = 1'b0;
    endcase
    gnt_o = (req_i == 2'b00) ? 2'b00 : onehot2(gnt_idx_o);
  end

endmodule

// File: rtl/speck_core_sequencer.sv
// Sequences two requesters onto a single Speck core: arbitration, key-reuse, timeout and response.
module speck_core_sequencer
  import speck_seq_pkg::*;
#(
  parameter int unsigned BLOCK_W = BlockWDef,
  parameter int unsigned KEY_W   = KeyWDef,
  parameter int unsigned TIMEOUT = TimeoutDef
) (
  input  logic                 ACLK,
  input  logic                 ARESET,
  input  logic [1:0]           req_valid,
  output logic [1:0]           req_ready,
  input  logic [1:0]           req_decrypt,
  input  logic [2*BLOCK_W-1:0] req_block,
  input  logic [2*KEY_W-1:0]   req_key,
  output logic [1:0]           rsp_valid,
  input  logic [1:0]           rsp_ready,
  output logic [BLOCK_W-1:0]   rsp_data,
  output logic                 rsp_err,
  output logic                 core_key_load,
  output logic [KEY_W-1:0]     core_key,
  input  logic                 core_key_done,
  output logic                 core_start,
  output logic                 core_decrypt,
  output logic [BLOCK_W-1:0]   core_block,
  input  logic                 core_done,
  input  logic [BLOCK_W-1:0]   core_result,
  output logic                 busy
);

  localparam logic [CntW-1:0] TimeoutLast = CntW'(TIMEOUT - 1);

  seq_state_e         state_q;
  logic               gnt_q;
  logic               key_valid_q;
  logic [KEY_W-1:0]   loaded_key_q;
  logic [CntW-1:0]    cnt_q;
  logic [1:0]         rsp_valid_q;
  logic [BLOCK_W-1:0] rsp_data_q;
  logic               rsp_err_q;
  logic               core_key_load_q;
  logic               core_start_q;
  logic [KEY_W-1:0]   core_key_q;
  logic [BLOCK_W-1:0] core_block_q;
  logic               core_decrypt_q;
  logic               busy_q;

  logic [1:0]         arb_gnt;
  logic               arb_idx;
  logic               accept;
  logic               rsp_take;
  logic [BLOCK_W-1:0] sel_block;
  logic [KEY_W-1:0]   sel_key;
  logic               sel_dec;
  logic               key_hit;
  logic               timeout_hit;

  assign accept      = (state_q == StIdle) && (req_valid != 2'b00);
  assign rsp_take    = (state_q == StResp) && rsp_ready[gnt_q];
  assign sel_block   = arb_idx ? req_block[2*BLOCK_W-1:BLOCK_W] : req_block[BLOCK_W-1:0];
  assign sel_key     = arb_idx ? req_key[2*KEY_W-1:KEY_W] : req_key[KEY_W-1:0];
  assign sel_dec     = req_decrypt[arb_idx];
  assign key_hit     = key_valid_q && (sel_key == loaded_key_q);
  assign timeout_hit = (cnt_q == TimeoutLast);

  speck_rr_arb2 u_arb (
    .clk_i     (ACLK),
    .rst_i     (ARESET),
    .req_i     (req_valid),
    .upd_i     (rsp_take),
    .upd_idx_i (gnt_q),
    .gnt_o     (arb_gnt),
    .gnt_idx_o (arb_idx)
  );

  // Handshake is combinational so the accept lands in the same cycle as the grant decision.
  assign req_ready     = ((state_q == StIdle) && !ARESET) ? arb_gnt : 2'b00;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_data      = rsp_data_q;
  assign rsp_err       = rsp_err_q;
  assign core_key_load = core_key_load_q;
  assign core_key      = core_key_q;
  assign core_start    = core_start_q;
  assign core_decrypt  = core_decrypt_q;
  assign core_block    = core_block_q;
  assign busy          = busy_q;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q         <= StIdle;
      gnt_q           <= 1'b0;
      key_valid_q     <= 1'b0;
      loaded_key_q    <= '0;
      cnt_q           <= '0;
      rsp_valid_q     <= 2'b00;
      rsp_data_q      <= '0;
      rsp_err_q       <= 1'b0;
      core_key_load_q <= 1'b0;
      core_start_q    <= 1'b0;
      core_key_q      <= '0;
      core_block_q    <= '0;
      core_decrypt_q  <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      core_key_load_q <= 1'b0;
      core_start_q    <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            gnt_q          <= arb_idx;
            core_block_q   <= sel_block;
            core_decrypt_q <= sel_dec;
            core_key_q     <= sel_key;
            busy_q         <= 1'b1;
            if (key_hit) begin
              state_q      <= StStart;
              core_start_q <= 1'b1;
            end else begin
              state_q         <= StKeyLoad;
              core_key_load_q <= 1'b1;
            end
          end
        end
        StKeyLoad: begin
          state_q <= StKeyWait;
          cnt_q   <= '0;
        end
        StKeyWait: begin
          if (core_key_done) begin
            key_valid_q  <= 1'b1;
            loaded_key_q <= core_key_q;
            state_q      <= StStart;
            core_start_q <= 1'b1;
          end else if (timeout_hit) begin
            key_valid_q <= 1'b0;
            rsp_err_q   <= 1'b1;
            rsp_data_q  <= '0;
            rsp_valid_q <= onehot2(gnt_q);
            state_q     <= StResp;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StStart: begin
          state_q <= StWait;
          cnt_q   <= '0;
        end
        StWait: begin
          if (core_done) begin
            rsp_data_q  <= core_result;
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= onehot2(gnt_q);
            state_q     <= StResp;
          end else if (timeout_hit) begin
            // A hung core leaves its key schedule in doubt, so force a reload next time.
            key_valid_q <= 1'b0;
            rsp_err_q   <= 1'b1;
            rsp_data_q  <= '0;
            rsp_valid_q <= onehot2(gnt_q);
            state_q     <= StResp;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StResp: begin
          if (rsp_ready[gnt_q]) begin
            rsp_valid_q <= 2'b00;
            rsp_err_q   <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule
